// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack CDC handshake; optional REQ abort timeout under `TIMEOUT_EN`
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_FF_STAGE  = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ack_async_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_e;

    state_e                   state_q, state_d;
    logic [SYNC_FF_STAGE-1:0] sync_q;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     req_q, done_q, err_q;
    logic                     ack_sync, accept, timeout, abort;

    if (SYNC_FF_STAGE < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("cdc_handshake_tx: SYNC_FF_STAGE and TIMEOUT_CYCLES must be >= 2");
    end

    assign ack_sync = sync_q[SYNC_FF_STAGE-1];
    assign ready_o  = (state_q == IDLE) & ~ack_sync;
    assign accept   = valid_i & ready_o;
    assign busy_o   = state_q != IDLE;
    assign req_o    = req_q;
    assign data_o   = data_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

`ifdef TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q;
    logic          abort_q;
    assign timeout = (state_q == REQ) & ~ack_sync & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign abort   = abort_q;
    // Count cycles spent in REQ; held at zero elsewhere so each REQ entry starts fresh
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= (state_q == REQ) ? cnt_q + 1'b1 : '0;
    // Remember an abort until IDLE so its WAIT_LOW exit is not reported as done
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) abort_q <= 1'b0;
        else         abort_q <= timeout | (abort_q & (state_q != IDLE));
`else
    assign timeout = 1'b0;
    assign abort   = 1'b0;
`endif

    // Ack synchronizer: shift the asynchronous ack through the flop chain
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_FF_STAGE-2:0], ack_async_i};

    // Next-state and held-word selection
    always_comb begin
        state_d = state_q;
        data_d  = accept ? data_i : data_q;
        case (state_q)
            IDLE:     if (accept) state_d = REQ;
            REQ:      if (ack_sync || timeout) state_d = WAIT_LOW;
            WAIT_LOW: if (!ack_sync) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and registered outputs; req follows the next state so it is high exactly in REQ
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            req_q   <= state_d == REQ;
            done_q  <= (state_q == WAIT_LOW) & ~ack_sync & ~abort;
            err_q   <= timeout;
        end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed and random-peer checks of the 4-phase handshake source
module tb_cdc_handshake_tx;
    localparam int DW = 8;
    localparam int S  = 3;
    localparam int TC = 16;
`ifdef TIMEOUT_EN
    localparam int MAXD = 8;
`else
    localparam int MAXD = 20;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          ack_async_i = 1'b0;
    logic          ready_o, req_o, busy_o, done_o, err_o;
    logic [DW-1:0] data_o;
    int            n_checks = 0;
    int            n_errors = 0;
    logic          prev_req = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] w;

    cdc_handshake_tx #(.DATA_WIDTH(DW), .SYNC_FF_STAGE(S), .TIMEOUT_CYCLES(TC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .req_o(req_o), .data_o(data_o), .ack_async_i(ack_async_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic logic sig(input int sel);
        return sel == 0 ? req_o : sel == 1 ? done_o : ready_o;
    endfunction

    task automatic wait_for(input int sel, input logic v, input string tag);
        int n;
        n = 0;
        while (sig(sel) !== v && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, 32'(sig(sel)), 32'(v));
    endtask

    task automatic finish_xfer(input string tag);
        ack_async_i = 1'b1;
        wait_for(0, 1'b0, {tag, "_req_fall"});
        ack_async_i = 1'b0;
        wait_for(1, 1'b1, {tag, "_done"});
        step(1);
    endtask

    // data_o must not move while req_o stays high
    always @(negedge clk_i) begin
        if (prev_req && req_o) chk("stable", 32'(data_o), 32'(prev_data));
        prev_req  = req_o;
        prev_data = data_o;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values and async reset mid-REQ
        step(2);
        chk("rst_req", 32'(req_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_ready", 32'(ready_o), 1);
        rst_ni = 1'b1;
        step(1);
        valid_i = 1'b1; data_i = 8'h3C;
        step(1);
        valid_i = 1'b0;
        chk("mid_req", 32'(req_o), 1);
        chk("mid_data", 32'(data_o), 32'h3C);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", 32'(req_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_data", 32'(data_o), 0);
        step(1);
        rst_ni = 1'b1;
        step(1);

        // single transfer, peer acks 4 clocks after req
        valid_i = 1'b1; data_i = 8'hA5;
        step(1);
        chk("x_req", 32'(req_o), 1);
        chk("x_data", 32'(data_o), 32'hA5);
        chk("x_busy", 32'(busy_o), 1);
        chk("x_ready", 32'(ready_o), 0);
        valid_i = 1'b0; data_i = 8'h00;
        step(3);
        chk("x_req_hold", 32'(req_o), 1);
        ack_async_i = 1'b1;
        step(3);
        chk("x_req_late", 32'(req_o), 1);
        step(1);
        chk("x_req_drop", 32'(req_o), 0);
        chk("x_wl_busy", 32'(busy_o), 1);
        chk("x_wl_data", 32'(data_o), 32'hA5);
        ack_async_i = 1'b0;
        step(3);
        chk("x_pre_done", 32'(done_o), 0);
        chk("x_pre_busy", 32'(busy_o), 1);
        step(1);
        chk("x_done", 32'(done_o), 1);
        chk("x_idle", 32'(busy_o), 0);
        chk("x_ready_after", 32'(ready_o), 1);
        chk("x_data_idle", 32'(data_o), 32'hA5);
        step(1);
        chk("x_done_pulse", 32'(done_o), 0);

        // valid held while busy: second word waits for done
        valid_i = 1'b1; data_i = 8'h11;
        step(1);
        chk("b_req", 32'(req_o), 1);
        chk("b_data1", 32'(data_o), 32'h11);
        data_i = 8'h22;
        ack_async_i = 1'b1;
        step(3);
        chk("b_hold_req", 32'(req_o), 1);
        chk("b_hold_data", 32'(data_o), 32'h11);
        step(1);
        chk("b_req_drop", 32'(req_o), 0);
        ack_async_i = 1'b0;
        step(3);
        chk("b_wl_data", 32'(data_o), 32'h11);
        chk("b_wl_ready", 32'(ready_o), 0);
        step(1);
        chk("b_done", 32'(done_o), 1);
        chk("b_data_still", 32'(data_o), 32'h11);
        step(1);
        chk("b_req2", 32'(req_o), 1);
        chk("b_data2", 32'(data_o), 32'h22);
        valid_i = 1'b0;
        finish_xfer("b");

        // ack stuck high across reset release
        rst_ni = 1'b0; ack_async_i = 1'b1;
        step(2);
        rst_ni = 1'b1;
        step(3);
        chk("s_ready0", 32'(ready_o), 0);
        valid_i = 1'b1; data_i = 8'h5A;
        step(2);
        chk("s_busy0", 32'(busy_o), 0);
        chk("s_ready1", 32'(ready_o), 0);
        ack_async_i = 1'b0;
        step(2);
        chk("s_ready2", 32'(ready_o), 0);
        chk("s_busy1", 32'(busy_o), 0);
        step(1);
        chk("s_ready3", 32'(ready_o), 1);
        step(1);
        chk("s_req", 32'(req_o), 1);
        chk("s_data", 32'(data_o), 32'h5A);
        valid_i = 1'b0;
        finish_xfer("s");

        // no ack: abort after TC cycles, or wait forever without the timeout
        valid_i = 1'b1; data_i = 8'hC3;
        step(1);
        valid_i = 1'b0;
        for (int k = 0; k < TC; k++) begin
            chk("t_req_high", 32'(req_o), 1);
            chk("t_err_low", 32'(err_o), 0);
            step(1);
        end
`ifdef TIMEOUT_EN
        chk("t_err", 32'(err_o), 1);
        chk("t_req_drop", 32'(req_o), 0);
        chk("t_busy", 32'(busy_o), 1);
        step(1);
        chk("t_err_pulse", 32'(err_o), 0);
        chk("t_no_done", 32'(done_o), 0);
        chk("t_idle", 32'(busy_o), 0);
        chk("t_ready", 32'(ready_o), 1);
        step(1);
        chk("t_no_done2", 32'(done_o), 0);
`else
        chk("t_req_stays", 32'(req_o), 1);
        chk("t_err_tied", 32'(err_o), 0);
        finish_xfer("t");
`endif

        // random words with a randomly slow peer
        for (int i = 0; i < 1000; i++) begin
            w = DW'($urandom);
            wait_for(2, 1'b1, "r_ready");
            valid_i = 1'b1; data_i = w;
            step(1);
            valid_i = 1'b0; data_i = DW'($urandom);
            chk("r_req", 32'(req_o), 1);
            chk("r_word", 32'(data_o), 32'(w));
            step($urandom_range(0, MAXD));
            ack_async_i = 1'b1;
            wait_for(0, 1'b0, "r_req_fall");
            step($urandom_range(0, 20));
            ack_async_i = 1'b0;
            wait_for(1, 1'b1, "r_done");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
